piso_bit_serializer: RTL and testbench

- Upstream stage for the bit-serial sequence detectors: accepts parallel words over a valid/ready handshake and emits them one bit per clock on a serial line.
- bit_out connects directly to a detector's serial `in`; bit_valid qualifies it.
- A one-word holding register lets back-to-back words stream with no idle cycle between them.

---
 rtl/piso_bit_serializer_pkg.sv | 15 +
 rtl/piso_bit_serializer_if.sv | 30 +++
 rtl/piso_bit_serializer.sv | 119 +++++++++++
 tb/tb_piso_bit_serializer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/piso_bit_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out bit serializer.
//   ser_state_e : serializer FSM state encoding
//   CNT_W()     : width of the bit-position counter for a given word width
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  function automatic int CNT_W(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_serializer_if.sv
// Word-load handshake and serial output bundle of the bit serializer.
//   data_in    : parallel word offered by the source
//   load_valid : data_in is valid this cycle
//   load_ready : holding register can accept a word this cycle
//   bit_out    : serial data bit
//   bit_valid  : bit_out carries a real bit
//   word_done  : last bit of a word is on bit_out
//   busy       : serializer is shifting or holding a word
// master = word source / serial consumer side, slave = serializer.
interface piso_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output data_in, load_valid,
    input  load_ready, bit_out, bit_valid, word_done, busy
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, bit_out, bit_valid, word_done, busy
  );
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in / serial-out bit serializer with a one-word holding register,
// so consecutive words stream with no idle cycle between them.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : piso_bit_serializer_if.slave (word handshake in, serial bits out)
// Parameters: WIDTH (2..32) bits per word, MSB_FIRST selects bit order.
//
// state | meaning
// IDLE  | no bit on the line; waits for the holding register to fill
// SHIFT | a word is being shifted out, cnt_q = index of the bit showing
module piso_bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  piso_bit_serializer_if.slave bus
);

  localparam int            CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             reload;

  // Bit that leaves next from a word aligned in the shifter.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the bit just sent so the next one moves to the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = bit_valid_q;
    reload       = 1'b0;

    if (bus.load_valid && !hold_valid_q) begin
      hold_d       = bus.data_in;
      hold_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        bit_valid_d = 1'b0;
        bit_out_d   = 1'b0;
        reload      = hold_valid_q;
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          // shift_q already has the showing bit removed
          bit_out_d = head_bit(shift_q);
          shift_d   = advance(shift_q);
          cnt_d     = cnt_q + CW'(1);
        end else if (hold_valid_q) begin
          reload = 1'b1;
        end else begin
          bit_valid_d = 1'b0;
          bit_out_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reload needs hold_valid_q=1, so it never coincides with an accept.
    if (reload) begin
      bit_out_d    = head_bit(hold_q);
      shift_d      = advance(hold_q);
      bit_valid_d  = 1'b1;
      cnt_d        = '0;
      hold_valid_d = 1'b0;
      state_d      = SHIFT;
    end
  end

  assign bus.load_ready = !hold_valid_q;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.word_done  = bit_valid_q && (cnt_q == LAST);
  assign bus.busy       = bit_valid_q || hold_valid_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: a 4-bit MSB-first instance driven
// from a vector table, plus hand-written sequences for reset mid-word and an
// 8-bit LSB-first instance.
module tb_piso_bit_serializer;

  logic clk;
  logic rst4;
  logic rst8;

  piso_bit_serializer_if #(.WIDTH(4)) bus4 ();
  piso_bit_serializer_if #(.WIDTH(8)) bus8 ();

  piso_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4.slave)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       lv;
    logic [3:0] d;
    logic       lr;
    logic       bo;
    logic       bv;
    logic       wd;
    logic       bz;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic r, logic lv, logic [3:0] d,
                              logic lr, logic bo, logic bv, logic wd, logic bz);
    vec_t v;
    v.rst = r;  v.lv = lv; v.d = d;
    v.lr  = lr; v.bo = bo; v.bv = bv; v.wd = wd; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int idx,
                      input logic lr, input logic bo, input logic bv,
                      input logic wd, input logic bz);
    n_vec++;
    chk({tag, ".load_ready"}, idx, bus4.load_ready, lr);
    chk({tag, ".bit_out"},    idx, bus4.bit_out,    bo);
    chk({tag, ".bit_valid"},  idx, bus4.bit_valid,  bv);
    chk({tag, ".word_done"},  idx, bus4.word_done,  wd);
    chk({tag, ".busy"},       idx, bus4.busy,       bz);
  endtask

  initial begin
    logic [3:0] w4;
    logic [7:0] w8;

    rst4 = 1'b1;  rst8 = 1'b1;
    bus4.load_valid = 1'b0;  bus4.data_in = '0;
    bus8.load_valid = 1'b0;  bus8.data_in = '0;

    // reset held three cycles with a word offered
    tbl.push_back(mk(1, 1, 4'b1101, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4'b1101, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4'b1101, 1, 0, 0, 0, 0));
    // single word 1101
    tbl.push_back(mk(0, 1, 4'b1101, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0, 0));
    // back-to-back 1011, 0110
    tbl.push_back(mk(0, 1, 4'b1011, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0110, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0110, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0, 0));
    // backpressure: only 1000 and 0111 are taken
    tbl.push_back(mk(0, 1, 4'b1000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0001, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0111, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'b1111, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0011, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst4            = tbl[i].rst;
      bus4.load_valid = tbl[i].lv;
      bus4.data_in    = tbl[i].d;
      step();
      chk4("tbl", i, tbl[i].lr, tbl[i].bo, tbl[i].bv, tbl[i].wd, tbl[i].bz);
    end

    // reset mid-word: 1111 shifting, 0101 held, rst after the 2nd bit
    bus4.load_valid = 1'b1;  bus4.data_in = 4'b1111;
    step();
    chk4("mid_accept", 0, 0, 0, 0, 0, 1);
    bus4.load_valid = 1'b0;
    step();
    chk4("mid_bit1", 0, 1, 1, 1, 0, 1);
    bus4.load_valid = 1'b1;  bus4.data_in = 4'b0101;
    step();
    chk4("mid_bit2", 0, 0, 1, 1, 0, 1);
    bus4.load_valid = 1'b0;  rst4 = 1'b1;
    step();
    chk4("mid_rst", 0, 1, 0, 0, 0, 0);
    rst4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk4("mid_discard", i, 1, 0, 0, 0, 0);
    end
    w4 = 4'b1001;
    bus4.load_valid = 1'b1;  bus4.data_in = w4;
    step();
    chk4("fresh_accept", 0, 0, 0, 0, 0, 1);
    bus4.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk4("fresh_bit", i, 1, w4[3-i], 1, (i == 3), 1);
    end
    step();
    chk4("fresh_end", 0, 1, 0, 0, 0, 0);

    // 8-bit LSB-first instance: A5 -> 1,0,1,0,0,1,0,1
    rst8 = 1'b0;
    step();
    n_vec++;
    chk("w8_idle.load_ready", 0, bus8.load_ready, 1'b1);
    chk("w8_idle.bit_valid",  0, bus8.bit_valid,  1'b0);
    w8 = 8'hA5;
    bus8.load_valid = 1'b1;  bus8.data_in = w8;
    step();
    n_vec++;
    chk("w8_accept.load_ready", 0, bus8.load_ready, 1'b0);
    chk("w8_accept.busy",       0, bus8.busy,       1'b1);
    bus8.load_valid = 1'b0;  bus8.data_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++;
      chk("w8_bit.bit_out",   i, bus8.bit_out,   w8[i]);
      chk("w8_bit.bit_valid", i, bus8.bit_valid, 1'b1);
      chk("w8_bit.word_done", i, bus8.word_done, (i == 7));
    end
    step();
    n_vec++;
    chk("w8_end.bit_valid", 0, bus8.bit_valid, 1'b0);
    chk("w8_end.bit_out",   0, bus8.bit_out,   1'b0);
    chk("w8_end.busy",      0, bus8.busy,      1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
